// File: rtl/audio_seq_pkg.sv
// Shared definitions for the audio effect sequencer: bus register map, FSM
// states, STATUS bit positions and the effect-length lookup.
package audio_seq_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_REQ    = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_FLUSH  = 2'd3;

  localparam int STAT_OVF_BIT  = 7;
  localparam int STAT_BUSY_BIT = 6;
  localparam int STAT_CLR_BIT  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_e;

  // Effect length in tempo steps; id 0 never reaches the FIFO.
  function automatic logic [3:0] effect_len(input logic [1:0] id);
    case (id)
      2'd1:    effect_len = 4'd3;
      2'd2:    effect_len = 4'd2;
      2'd3:    effect_len = 4'd1;
      default: effect_len = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/audio_effect_sequencer_fifo.sv
// audio_cmd_fifo: request FIFO of 2-bit effect ids with push/pop/flush and an
// atomic flush-then-push (reload) used by request preemption.
module audio_cmd_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic       reload,
  input  logic [1:0] push_data,
  output logic [1:0] pop_data,
  output logic       full,
  output logic       empty,
  output logic [3:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]       count_q, count_d;
  logic             push_ok, pop_ok, do_write;

  assign full     = (count_q == 4'(DEPTH));
  assign empty    = (count_q == 4'd0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    push_ok  = push && (!full || pop);
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_write = 1'b0;
    if (flush) begin
      // Flush discards any queued entries; only a reload keeps the new push.
      rd_ptr_d = wr_ptr_q;
      count_d  = 4'd0;
      if (reload && push) begin
        do_write = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d  = 4'd1;
      end
    end else begin
      if (push_ok) begin
        do_write = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + 4'(push_ok) - 4'(pop_ok);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; count and pointers alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/audio_effect_sequencer.sv
// Bus front end driving the 4-bit AudioControlRegister: soundtrack enable plus
// queued sound effects. Optional preemption: define AUDIO_SEQ_PREEMPT_EN.
module audio_effect_sequencer
  import audio_seq_pkg::*;
#(
  parameter int TICKS_PER_STEP = 20000000,
  parameter int DEPTH          = 8,
  parameter int GAP_STEPS      = 1
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       WriteEnable,
  input  logic [1:0] Address,
  input  logic [7:0] WriteData,
  output logic [7:0] ReadData,
  output logic [3:0] AudioControlRegister,
  output logic [3:0] QueueCount
);

  localparam int PRESC_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;

  logic [PRESC_W-1:0] presc_q, presc_d;
  seq_state_e         state_q, state_d;
  logic [7:0]         step_q, step_d;
  logic [1:0]         sel_q, sel_d;
  logic               sound_q, sound_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         rdata_q, rdata_d;

  logic       tick, busy;
  logic       wr_ctrl, wr_req, wr_status, wr_flush;
  logic       req_valid, preempt, ovf_set;
  logic       fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [1:0] fifo_dout;
  logic [3:0] fifo_count, acr;
  logic [7:0] status;
  logic       unused_wdata;

  assign unused_wdata = ^WriteData[6:2];

  audio_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .Reset     (Reset),
    .push      (req_valid),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .reload    (preempt),
    .push_data (WriteData[1:0]),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    wr_ctrl   = WriteEnable && (Address == ADDR_CTRL);
    wr_req    = WriteEnable && (Address == ADDR_REQ);
    wr_status = WriteEnable && (Address == ADDR_STATUS);
    wr_flush  = WriteEnable && (Address == ADDR_FLUSH);
    req_valid = wr_req && (WriteData[1:0] != 2'b00);
`ifdef AUDIO_SEQ_PREEMPT_EN
    preempt   = req_valid && WriteData[7];
`else
    preempt   = 1'b0;
`endif
    fifo_flush = wr_flush || preempt;
  end

  always_comb begin
    tick    = (presc_q == PRESC_W'(TICKS_PER_STEP - 1));
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    sel_d    = sel_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_PLAY;
          sel_d    = fifo_dout;
          step_d   = 8'(effect_len(fifo_dout)) + 8'd1;
        end
      end
      ST_PLAY: begin
        if (preempt || (tick && step_q == 8'd1)) begin
          state_d = ST_GAP;
          step_d  = 8'(GAP_STEPS);
        end else if (tick) begin
          step_d = step_q - 8'd1;
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (step_q == 8'd1) begin
            state_d = ST_IDLE;
            sel_d   = 2'b00;
          end else begin
            step_d = step_q - 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    acr  = {sound_q, state_q == ST_PLAY, sel_q};

    status                = 8'h00;
    status[STAT_OVF_BIT]  = ovf_q;
    status[STAT_BUSY_BIT] = busy;
    status[3:0]           = fifo_count;

    sound_d = wr_ctrl ? WriteData[0] : sound_q;

    // A dropped push beats a same-cycle clear so no overflow goes unreported.
    ovf_set = req_valid && fifo_full && !fifo_pop && !fifo_flush;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (wr_status && WriteData[STAT_CLR_BIT]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    rdata_d = (Address == ADDR_STATUS) ? status : {4'b0000, acr};
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      presc_q <= '0;
      state_q <= ST_IDLE;
      step_q  <= 8'd0;
      sel_q   <= 2'b00;
      sound_q <= 1'b0;
      ovf_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      presc_q <= presc_d;
      state_q <= state_d;
      step_q  <= step_d;
      sel_q   <= sel_d;
      sound_q <= sound_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  assign AudioControlRegister = acr;
  assign QueueCount           = fifo_count;
  assign ReadData             = rdata_q;

endmodule

// File: tb/tb_audio_effect_sequencer.sv
// Scoreboard bench: a timestamp-based reference model predicts every cycle's
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_audio_effect_sequencer;

  localparam int T     = 4;
  localparam int DEPTH = 8;
  localparam int GAP   = 1;
`ifdef AUDIO_SEQ_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic       CLK;
  logic       Reset;
  logic       WriteEnable;
  logic [1:0] Address;
  logic [7:0] WriteData;
  logic [7:0] ReadData;
  logic [3:0] AudioControlRegister;
  logic [3:0] QueueCount;

  audio_effect_sequencer #(
    .TICKS_PER_STEP (T),
    .DEPTH          (DEPTH),
    .GAP_STEPS      (GAP)
  ) dut (
    .CLK                  (CLK),
    .Reset                (Reset),
    .WriteEnable          (WriteEnable),
    .Address              (Address),
    .WriteData            (WriteData),
    .ReadData             (ReadData),
    .AudioControlRegister (AudioControlRegister),
    .QueueCount           (QueueCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    longint     cyc;
    logic [3:0] acr;
    logic [3:0] qc;
    logic [7:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: queue of ids plus the cycle numbers at which the current
  // effect's enable and select end, derived from tick timestamps.
  int         mq[$];
  bit         m_valid = 1'b0;
  bit         m_st, m_ovf, m_busy;
  int         m_sel;
  longint     m_en_until, m_sel_until;
  longint     m_cyc = 0;
  longint     m_base = 0;
  logic [7:0] m_rd_next;

  function automatic longint first_tick(input longint from);
    longint ph;
    ph = (from - m_base) % T;
    return from + (T - 1 - ph);
  endfunction

  task automatic check(input string name, input longint cyc,
                       input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cycle %0d: got 0x%02h, want 0x%02h", name, cyc, got, want);
    end
  endtask

  task automatic model_step(input logic rst, input logic we, input logic [1:0] a,
                            input logic [7:0] d, output exp_t e);
    bit         playing, pop, full_before;
    logic [3:0] acr;
    logic [7:0] status;
    if (m_busy && m_cyc > m_sel_until) m_busy = 1'b0;
    playing = m_busy && (m_cyc <= m_en_until);
    acr     = {m_st, playing, m_busy ? 2'(m_sel) : 2'b00};
    status  = {m_ovf, m_busy, 2'b00, 4'(mq.size())};
    e.cyc   = m_cyc;
    e.acr   = acr;
    e.qc    = 4'(mq.size());
    e.rd    = m_rd_next;
    if (rst) begin
      m_st = 1'b0; m_ovf = 1'b0; m_busy = 1'b0; m_sel = 0;
      mq.delete();
      m_rd_next = 8'h00;
      m_base = m_cyc + 1;
    end else begin
      m_rd_next   = (a == 2'd2) ? status : {4'h0, acr};
      full_before = (mq.size() == DEPTH);
      pop         = !m_busy && (mq.size() > 0);
      if (pop) begin
        m_sel       = mq.pop_front();
        m_busy      = 1'b1;
        m_en_until  = first_tick(m_cyc + 1) + longint'(4 - m_sel) * T;
        m_sel_until = m_en_until + longint'(GAP) * T;
      end
      if (we) begin
        case (a)
          2'd0: m_st = d[0];
          2'd1: if (d[1:0] != 2'b00) begin
            if (PREEMPT && d[7]) begin
              mq.delete();
              mq.push_back(int'(d[1:0]));
              if (playing) begin
                m_en_until  = m_cyc;
                m_sel_until = first_tick(m_cyc + 1) + longint'(GAP - 1) * T;
              end
            end else if (full_before && !pop) begin
              m_ovf = 1'b1;
            end else begin
              mq.push_back(int'(d[1:0]));
            end
          end
          2'd2: if (d[7]) m_ovf = 1'b0;
          default: mq.delete();
        endcase
      end
    end
    m_cyc++;
  endtask

  task automatic drive(input logic rst, input logic we, input logic [1:0] a,
                       input logic [7:0] d);
    exp_t e;
    bit   was_valid;
    @(posedge CLK);
    #1;
    was_valid   = m_valid;
    Reset       = rst;
    WriteEnable = we;
    Address     = a;
    WriteData   = d;
    model_step(rst, we, a, d, e);
    if (was_valid) exp_q.push_back(e);
    if (rst) m_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'($urandom_range(0, 3)), 8'h00);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (m_busy || mq.size() > 0); i++) idle(1);
    idle(3);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("acr", e.cyc, {4'h0, AudioControlRegister}, {4'h0, e.acr});
      check("queue_count", e.cyc, {4'h0, QueueCount}, {4'h0, e.qc});
      check("read_data", e.cyc, ReadData, e.rd);
    end
  end

  initial begin
    int r;
    CLK = 1'b0; Reset = 1'b1; WriteEnable = 1'b0; Address = 2'd0; WriteData = 8'h00;

    repeat (3) drive(1'b1, 1'b0, 2'd0, 8'h00);
    // Soundtrack enable and an idle STATUS read.
    drive(1'b0, 1'b1, 2'd0, 8'h01);
    idle(2);
    drive(1'b0, 1'b0, 2'd2, 8'h00);
    idle(2);
    // Single effect, then two back to back.
    drive(1'b0, 1'b1, 2'd1, 8'h01);
    idle(30);
    drive(1'b0, 1'b1, 2'd1, 8'h02);
    drive(1'b0, 1'b1, 2'd1, 8'h03);
    idle(50);
    // Overflow while playing, then clear it.
    drive(1'b0, 1'b1, 2'd1, 8'h01);
    idle(3);
    repeat (9) drive(1'b0, 1'b1, 2'd1, 8'h02);
    drive(1'b0, 1'b0, 2'd2, 8'h00);
    idle(1);
    drive(1'b0, 1'b1, 2'd2, 8'h80);
    drive(1'b0, 1'b0, 2'd2, 8'h00);
    idle(1);
    drain(600);
    // Flush during play with three queued.
    drive(1'b0, 1'b1, 2'd1, 8'h01);
    drive(1'b0, 1'b1, 2'd1, 8'h02);
    drive(1'b0, 1'b1, 2'd1, 8'h03);
    drive(1'b0, 1'b1, 2'd1, 8'h01);
    idle(3);
    drive(1'b0, 1'b1, 2'd3, 8'h5A);
    idle(40);
    // Id 0 requests are ignored.
    drive(1'b0, 1'b1, 2'd1, 8'h00);
    drive(1'b0, 1'b1, 2'd1, 8'h7C);
    idle(5);
    // Reset in the middle of an effect.
    drive(1'b0, 1'b1, 2'd1, 8'h03);
    idle(4);
    drive(1'b1, 1'b0, 2'd0, 8'h00);
    idle(10);
    // Request with bit 7 set during play (preempts only when enabled).
    drive(1'b0, 1'b1, 2'd1, 8'h01);
    drive(1'b0, 1'b1, 2'd1, 8'h02);
    drive(1'b0, 1'b1, 2'd1, 8'h02);
    idle(4);
    drive(1'b0, 1'b1, 2'd1, 8'h83);
    drain(400);
    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 3)         drive(1'b1, 1'b0, 2'd0, 8'h00);
      else if (r < 160)  drive(1'b0, 1'b1, 2'd1, 8'($urandom_range(0, 255)));
      else if (r < 190)  drive(1'b0, 1'b1, 2'd0, 8'($urandom_range(0, 255)));
      else if (r < 220)  drive(1'b0, 1'b1, 2'd2, 8'($urandom_range(0, 255)));
      else if (r < 235)  drive(1'b0, 1'b1, 2'd3, 8'($urandom_range(0, 255)));
      else               idle(1);
    end
    drain(1000);

    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("scoreboard_drained", m_cyc, 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
